// File: rtl/tweet_recorder_if.sv
// Control and status bundle of the tweet_recorder UART record/playback engine.
// The board-side controller holds the master end; the recorder holds the slave end.
interface tweet_recorder_if #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 256
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                 enable;
  logic                 serial_in;
  logic                 play;
  logic                 loop_mode;
  logic                 echo_en;
  logic                 clear;
  logic                 serial_out;
  logic                 rx_valid;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_frame_err;
  logic [ADDR_W:0]      count;
  logic                 overflow;
  logic                 busy_play;

  modport master (
    output enable, serial_in, play, loop_mode, echo_en, clear,
    input  serial_out, rx_valid, rx_data, rx_frame_err, count, overflow, busy_play
  );

  modport slave (
    input  enable, serial_in, play, loop_mode, echo_en, clear,
    output serial_out, rx_valid, rx_data, rx_frame_err, count, overflow, busy_play
  );
endinterface

// File: rtl/tweet_recorder.sv
// UART record/playback engine: characters received on serial_in are kept in a circular RAM
// and replayed on serial_out once or in a loop; received characters may also be echoed live.
module tweet_recorder #(
  parameter int DATA_BITS    = 8,
  parameter int DEPTH        = 256,
  parameter int CLKS_PER_BIT = 5207,
  parameter int CHAR_GAP     = 78105
) (
  input logic             sysclk,
  input logic             reset_n,
  tweet_recorder_if.slave bus
);
  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int TX_MAX   = (CLKS_PER_BIT > CHAR_GAP) ? CLKS_PER_BIT : CHAR_GAP;
  localparam int RXC_W    = $clog2(CLKS_PER_BIT);
  localparam int TXC_W    = $clog2(TX_MAX);
  localparam int BIT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef logic [DATA_BITS-1:0] data_t;
  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [ADDR_W:0]      cnt_t;
  typedef logic [RXC_W-1:0]     rxc_t;
  typedef logic [TXC_W-1:0]     txc_t;
  typedef logic [BIT_W-1:0]     bit_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_STOP, TX_GAP} tx_state_t;

  // Dropping enable is a soft reset that leaves the RAM untouched.
  logic rst;
  assign rst = !reset_n || !bus.enable;

  // ---------------------------------------------------------------- input synchroniser
  logic sync_q1, sync_q2, rx_line;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= bus.serial_in;
      sync_q2 <= sync_q1;
    end
  end
  assign rx_line = sync_q2;

  // ---------------------------------------------------------------- receiver
  rx_state_t rx_state, rx_state_n;
  rxc_t      rx_cnt, rx_cnt_n;
  bit_t      rx_bit, rx_bit_n;
  data_t     rx_shift, rx_shift_n;
  logic      rx_good, rx_bad;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + rxc_t'(1);
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_good    = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (!rx_line) rx_state_n = RX_START;
      end
      RX_START: begin
        // Mid start bit: a line that is high again was only a glitch.
        if (rx_cnt == rxc_t'(HALF_BIT - 1)) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_line ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == rxc_t'(CLKS_PER_BIT - 1)) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_line, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == bit_t'(DATA_BITS - 1)) rx_state_n = RX_STOP;
          else                                 rx_bit_n   = rx_bit + bit_t'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == rxc_t'(CLKS_PER_BIT - 1)) begin
          rx_cnt_n   = '0;
          rx_state_n = RX_IDLE;
          rx_good    = rx_line;
          rx_bad     = !rx_line;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  logic  rx_valid_q, rx_err_q;
  data_t rx_data_q;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_valid_q <= rx_good;
      rx_err_q   <= rx_bad;
      if (rx_good) rx_data_q <= rx_shift;
    end
  end

  // ---------------------------------------------------------------- buffer bookkeeping
  addr_t wr_ptr;
  cnt_t  count;
  logic  overflow;
  logic  busy_play;
  logic  clear_ok, wr_en;

  assign clear_ok = bus.clear && !busy_play;
  assign wr_en    = rx_good && !clear_ok && (count != cnt_t'(DEPTH));

  always_ff @(posedge sysclk) begin
    if (rst) begin
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear_ok) begin
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (rx_good) begin
      if (count == cnt_t'(DEPTH)) begin
        overflow <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr + addr_t'(1);
        count  <= count + cnt_t'(1);
      end
    end
  end

  tx_state_t tx_state, tx_state_n;
  addr_t     rd_ptr, rd_ptr_n;
  data_t     mem [DEPTH];
  data_t     ram_q;

  // NOTE: the RAM is deliberately not reset; it keeps its contents across enable drops.
  always_ff @(posedge sysclk) begin
    if (wr_en) mem[wr_ptr] <= rx_shift;
    if (tx_state == TX_LOAD) ram_q <= mem[rd_ptr];
  end

  // ---------------------------------------------------------------- transmitter
  txc_t  tx_cnt, tx_cnt_n;
  bit_t  tx_bit, tx_bit_n;
  data_t tx_shift, tx_shift_n;
  cnt_t  len, len_n;
  logic  busy_n, abort_req, abort_n, is_echo, echo_n;
  logic  start_play, abort_hit, echo_go;
  logic  line_n, serial_out_q;

  assign start_play = bus.play && !busy_play && (count != '0);
  assign abort_hit  = bus.play && busy_play;
  assign echo_go    = rx_valid_q && bus.echo_en && !busy_play && (tx_state == TX_IDLE)
                      && !start_play;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      tx_state     <= TX_IDLE;
      tx_cnt       <= '0;
      tx_bit       <= '0;
      tx_shift     <= '0;
      rd_ptr       <= '0;
      len          <= '0;
      busy_play    <= 1'b0;
      abort_req    <= 1'b0;
      is_echo      <= 1'b0;
      serial_out_q <= 1'b1;
    end else begin
      tx_state     <= tx_state_n;
      tx_cnt       <= tx_cnt_n;
      tx_bit       <= tx_bit_n;
      tx_shift     <= tx_shift_n;
      rd_ptr       <= rd_ptr_n;
      len          <= len_n;
      busy_play    <= busy_n;
      abort_req    <= abort_n;
      is_echo      <= echo_n;
      serial_out_q <= line_n;
    end
  end

  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt + txc_t'(1);
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    rd_ptr_n   = rd_ptr;
    len_n      = len;
    busy_n     = busy_play;
    abort_n    = abort_req | abort_hit;
    echo_n     = is_echo;
    if (start_play) begin
      busy_n   = 1'b1;
      len_n    = count;
      rd_ptr_n = '0;
      abort_n  = 1'b0;
    end
    case (tx_state)
      TX_IDLE: begin
        tx_cnt_n = '0;
        if (start_play) begin
          tx_state_n = TX_LOAD;
          echo_n     = 1'b0;
        end else if (echo_go) begin
          tx_state_n = TX_START;
          echo_n     = 1'b1;
          tx_shift_n = rx_data_q;
        end
      end
      TX_LOAD: begin
        tx_cnt_n = '0;
        if (abort_n) begin
          tx_state_n = TX_IDLE;
          busy_n     = 1'b0;
          abort_n    = 1'b0;
        end else begin
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == txc_t'(CLKS_PER_BIT - 1)) begin
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
          if (!is_echo) tx_shift_n = ram_q;
        end
      end
      TX_DATA: begin
        if (tx_cnt == txc_t'(CLKS_PER_BIT - 1)) begin
          tx_cnt_n   = '0;
          tx_shift_n = tx_shift >> 1;
          if (tx_bit == bit_t'(DATA_BITS - 1)) tx_state_n = TX_STOP;
          else                                 tx_bit_n   = tx_bit + bit_t'(1);
        end
      end
      TX_STOP: begin
        if (tx_cnt == txc_t'(CLKS_PER_BIT - 1)) begin
          tx_cnt_n = '0;
          echo_n   = 1'b0;
          if (abort_n) begin
            tx_state_n = TX_IDLE;
            busy_n     = 1'b0;
            abort_n    = 1'b0;
          end else if (is_echo) begin
            // A playback requested while an echo was on the line starts right after it.
            tx_state_n = (busy_play || start_play) ? TX_LOAD : TX_IDLE;
          end else begin
            tx_state_n = TX_GAP;
          end
        end
      end
      TX_GAP: begin
        if (abort_n) begin
          tx_state_n = TX_IDLE;
          tx_cnt_n   = '0;
          busy_n     = 1'b0;
          abort_n    = 1'b0;
        end else if (tx_cnt == txc_t'(CHAR_GAP - 1)) begin
          tx_cnt_n = '0;
          if (rd_ptr == addr_t'(len - cnt_t'(1))) begin
            if (bus.loop_mode) begin
              rd_ptr_n   = '0;
              tx_state_n = TX_LOAD;
            end else begin
              tx_state_n = TX_IDLE;
              busy_n     = 1'b0;
            end
          end else begin
            rd_ptr_n   = rd_ptr + addr_t'(1);
            tx_state_n = TX_LOAD;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase

    // The line is registered from the next state so it never glitches on decode.
    case (tx_state_n)
      TX_START: line_n = 1'b0;
      TX_DATA:  line_n = tx_shift_n[0];
      default:  line_n = 1'b1;
    endcase
  end

  assign bus.serial_out   = serial_out_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_frame_err = rx_err_q;
  assign bus.count        = count;
  assign bus.overflow     = overflow;
  assign bus.busy_play    = busy_play;
endmodule
